load_store_unit: RTL

//  Data-memory access stage downstream of the instruction decoder. It takes one load/store

---
 rtl/load_store_unit.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Data-memory load/store stage: turns one command into one or two aligned word bus
// transactions, places store bytes on their lanes and extends load results for rd.
module load_store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  // CAPT is the cycle between the last ack and done in which the load result is formed.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    REQ1 = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic        store_r, store_s;
  logic [2:0]  size_r, size_s;
  logic [1:0]  off_r, off_s;
  logic [31:0] wdata_r, wdata_s;
  logic [31:0] r0_r, r0_s, r1_r, r1_s;
  logic [31:0] load_data_r, load_data_s;
  logic        done_r, done_s, err_r, err_s;
  logic        bus_req_r, bus_req_s, bus_we_r, bus_we_s;
  logic [31:0] bus_addr_r, bus_addr_s, bus_wdata_r, bus_wdata_s;
  logic [3:0]  bus_wstrb_r, bus_wstrb_s;

  logic [1:0]  lane_off_s;
  logic [2:0]  lane_size_s;
  logic [31:0] lane_data_s;
  logic [7:0]  mask_s;
  logic [63:0] data_s;
  logic [2:0]  span_s;
  logic        cross_s;
  logic        size_ok_s;
  logic [31:0] rd_s;

  function automatic logic [2:0] size_nbytes(input logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: size_nbytes = 3'd1;
      3'b001, 3'b101: size_nbytes = 3'd2;
      3'b010:         size_nbytes = 3'd4;
      default:        size_nbytes = 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: size_mask = 4'b0001;
      3'b001, 3'b101: size_mask = 4'b0011;
      3'b010:         size_mask = 4'b1111;
      default:        size_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] sz, input logic [31:0] s);
    case (sz)
      3'b000:  extend = {{24{s[7]}}, s[7:0]};
      3'b100:  extend = {24'd0, s[7:0]};
      3'b001:  extend = {{16{s[15]}}, s[15:0]};
      3'b101:  extend = {16'd0, s[15:0]};
      default: extend = s;
    endcase
  endfunction

  // Lane placement uses the live inputs while accepting a command, latched copies after.
  always_comb begin
    lane_off_s  = (state_r == IDLE) ? addr[1:0] : off_r;
    lane_size_s = (state_r == IDLE) ? size      : size_r;
    lane_data_s = (state_r == IDLE) ? wdata     : wdata_r;
    mask_s      = {4'd0, size_mask(lane_size_s)} << lane_off_s;
    data_s      = {32'd0, lane_data_s} << {lane_off_s, 3'b000};
    span_s      = {1'b0, lane_off_s} + size_nbytes(lane_size_s);
    cross_s     = (span_s > 3'd4);
    size_ok_s   = (size_nbytes(lane_size_s) != 3'd0);
    rd_s        = 32'({r1_r, r0_r} >> {off_r, 3'b000});
  end

  // Next-state and next-output logic for the command sequencer.
  always_comb begin
    state_s     = state_r;
    store_s     = store_r;
    size_s      = size_r;
    off_s       = off_r;
    wdata_s     = wdata_r;
    r0_s        = r0_r;
    r1_s        = r1_r;
    load_data_s = load_data_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    bus_req_s   = bus_req_r;
    bus_we_s    = bus_we_r;
    bus_addr_s  = bus_addr_r;
    bus_wstrb_s = bus_wstrb_r;
    bus_wdata_s = bus_wdata_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          store_s = is_store;
          size_s  = size;
          off_s   = addr[1:0];
          wdata_s = wdata;
          r1_s    = 32'd0;
          if (!size_ok_s || (cross_s && !ALLOW_MISALIGNED)) begin
            state_s = DONE;
            done_s  = 1'b1;
            err_s   = 1'b1;
          end else begin
            state_s     = REQ0;
            bus_req_s   = 1'b1;
            bus_we_s    = is_store;
            bus_addr_s  = {addr[31:2], 2'b00};
            bus_wstrb_s = is_store ? mask_s[3:0] : 4'b0000;
            bus_wdata_s = data_s[31:0];
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ0: begin
        if (bus_ack) begin
          r0_s      = bus_rdata;
          bus_req_s = 1'b0;
          state_s   = cross_s ? REQ1 : CAPT;
        end else begin
          state_s = REQ0;
        end
      end
      REQ1: begin
        // First REQ1 cycle is the mandatory req-low gap; bus_addr still holds word 0.
        if (!bus_req_r) begin
          bus_req_s   = 1'b1;
          bus_addr_s  = bus_addr_r + 32'd4;
          bus_wstrb_s = store_r ? mask_s[7:4] : 4'b0000;
          bus_wdata_s = data_s[63:32];
        end else if (bus_ack) begin
          r1_s      = bus_rdata;
          bus_req_s = 1'b0;
          state_s   = CAPT;
        end else begin
          state_s = REQ1;
        end
      end
      CAPT: begin
        state_s = DONE;
        done_s  = 1'b1;
        if (!store_r) begin
          load_data_s = extend(size_r, rd_s);
        end else begin
          load_data_s = load_data_r;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        bus_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset also abandons any outstanding bus request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      store_r     <= 1'b0;
      size_r      <= 3'd0;
      off_r       <= 2'd0;
      wdata_r     <= 32'd0;
      r0_r        <= 32'd0;
      r1_r        <= 32'd0;
      load_data_r <= 32'd0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'd0;
      bus_wstrb_r <= 4'd0;
      bus_wdata_r <= 32'd0;
    end else begin
      state_r     <= state_s;
      store_r     <= store_s;
      size_r      <= size_s;
      off_r       <= off_s;
      wdata_r     <= wdata_s;
      r0_r        <= r0_s;
      r1_r        <= r1_s;
      load_data_r <= load_data_s;
      done_r      <= done_s;
      err_r       <= err_s;
      bus_req_r   <= bus_req_s;
      bus_we_r    <= bus_we_s;
      bus_addr_r  <= bus_addr_s;
      bus_wstrb_r <= bus_wstrb_s;
      bus_wdata_r <= bus_wdata_s;
    end
  end

  assign busy      = (state_r != IDLE);
  assign done      = done_r;
  assign err       = err_r;
  assign load_data = load_data_r;
  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wstrb = bus_wstrb_r;
  assign bus_wdata = bus_wdata_r;

endmodule
